// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I ALU instructions into opcode/operands behind a 2-entry skid buffer.
// Optional perf counters (perf_issued, perf_stall) are enabled with `define ALU_ISSUE_PERF_EN.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [OPW-1:0]  ex_op,
    output logic [4:0]      ex_rd,
    output logic            ex_we,
    output logic            illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall
`endif
);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(8);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(9);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [OPW-1:0]  op;
        logic [4:0]      rd;
        logic            we;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t  state_q, state_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    logic    illegal_q, illegal_d;

    bundle_t dec;
    logic    dec_legal;
    logic    accept;
    logic    fire;
    logic    push;

    // alt selects SUB over ADD and SRA over SRL
    function automatic logic [OPW-1:0] op_from_f3(input logic [2:0] f3, input logic alt);
        logic [OPW-1:0] op;
        op = OP_ADD;
        case (f3)
            3'b000:  op = alt ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = alt ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       is_shift;
        opcode    = in_instr[6:0];
        f3        = in_instr[14:12];
        f7        = in_instr[31:25];
        is_shift  = (f3 == 3'b001) || (f3 == 3'b101);
        dec       = '0;
        dec_legal = 1'b0;
        dec.rd    = in_instr[11:7];
        dec.we    = (in_instr[11:7] != 5'd0);
        case (opcode)
            OPC_OP: begin
                dec.a     = in_rs1_data;
                dec.b     = in_rs2_data;
                dec.op    = op_from_f3(f3, f7 == 7'h20);
                dec_legal = (f7 == 7'h00) ||
                            ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_OPIMM: begin
                dec.a     = in_rs1_data;
                dec.b     = is_shift ? {{(XLEN-5){1'b0}}, in_instr[24:20]}
                                     : {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                dec.op    = op_from_f3(f3, (f3 == 3'b101) && (f7 == 7'h20));
                if (f3 == 3'b001)
                    dec_legal = (f7 == 7'h00);
                else if (f3 == 3'b101)
                    dec_legal = (f7 == 7'h00) || (f7 == 7'h20);
                else
                    dec_legal = 1'b1;
            end
            OPC_LUI: begin
                dec.b     = {in_instr[31:12], 12'b0};
                dec.op    = OP_ADD;
                dec_legal = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a     = in_pc;
                dec.b     = {in_instr[31:12], 12'b0};
                dec.op    = OP_ADD;
                dec_legal = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign ex_valid = (state_q != EMPTY);
    assign in_ready = (state_q != TWO);
    assign accept   = in_valid && in_ready;
    assign fire     = ex_valid && ex_ready;
    assign push     = accept && dec_legal;

    // Flush wins over everything; a bundle firing this cycle still leaves normally.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        skid_d    = skid_q;
        illegal_d = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            illegal_d = accept && !dec_legal;
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        out_d   = dec;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (fire && push) begin
                        out_d = dec;
                    end else if (fire) begin
                        state_d = EMPTY;
                    end else if (push) begin
                        skid_d  = dec;
                        state_d = TWO;
                    end
                end
                TWO: begin
                    if (fire) begin
                        out_d   = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_a    = out_q.a;
    assign ex_b    = out_q.b;
    assign ex_op   = out_q.op;
    assign ex_rd   = out_q.rd;
    assign ex_we   = out_q.we;
    assign illegal = illegal_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Counters ignore flush and wrap naturally.
    always_comb begin
        perf_issued_d = perf_issued_q + {31'b0, fire};
        perf_stall_d  = perf_stall_q + {31'b0, (ex_valid && !ex_ready)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: queue-based reference model plus directed literal checks.
// Define ALU_ISSUE_PERF_EN to also check the perf counters.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [3:0]  ex_op;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    int checks   = 0;
    int failures = 0;

    alu_issue_stage #(.XLEN(32), .OPW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .ex_op       (ex_op),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .illegal     (illegal)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order list of at most two pending bundles.
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        legal;
    } exp_t;

    exp_t        model_q[$];
    logic        exp_illegal;
    logic [31:0] exp_issued;
    logic [31:0] exp_stall;

    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t e;
        e.a     = rs1;
        e.b     = rs2;
        e.op    = 4'd0;
        e.rd    = ins[11:7];
        e.we    = (ins[11:7] != 5'd0);
        e.legal = 1'b1;
        if (ins[6:0] == 7'b0110011) begin
            case ({ins[31:25], ins[14:12]})
                {7'h00, 3'd0}: e.op = 4'd0;
                {7'h20, 3'd0}: e.op = 4'd1;
                {7'h00, 3'd7}: e.op = 4'd2;
                {7'h00, 3'd6}: e.op = 4'd3;
                {7'h00, 3'd4}: e.op = 4'd4;
                {7'h00, 3'd1}: e.op = 4'd5;
                {7'h00, 3'd5}: e.op = 4'd6;
                {7'h20, 3'd5}: e.op = 4'd7;
                {7'h00, 3'd2}: e.op = 4'd8;
                {7'h00, 3'd3}: e.op = 4'd9;
                default:       e.legal = 1'b0;
            endcase
        end else if (ins[6:0] == 7'b0010011) begin
            e.b = 32'($signed(ins[31:20]));
            case (ins[14:12])
                3'd0: e.op = 4'd0;
                3'd7: e.op = 4'd2;
                3'd6: e.op = 4'd3;
                3'd4: e.op = 4'd4;
                3'd2: e.op = 4'd8;
                3'd3: e.op = 4'd9;
                3'd1: begin
                    e.b     = 32'(ins[24:20]);
                    e.op    = 4'd5;
                    e.legal = (ins[31:25] == 7'h00);
                end
                default: begin
                    e.b     = 32'(ins[24:20]);
                    e.op    = (ins[31:25] == 7'h20) ? 4'd7 : 4'd6;
                    e.legal = (ins[31:25] == 7'h00) || (ins[31:25] == 7'h20);
                end
            endcase
        end else if (ins[6:0] == 7'b0110111 || ins[6:0] == 7'b0010111) begin
            e.a = (ins[6:0] == 7'b0010111) ? pc : 32'd0;
            e.b = ins & 32'hFFFF_F000;
        end else begin
            e.legal = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            exp_illegal = 1'b0;
            exp_issued  = 32'd0;
            exp_stall   = 32'd0;
        end else begin
            exp_t e;
            logic acc;
            logic fir;
            acc = in_valid && (model_q.size() < 2);
            fir = (model_q.size() > 0) && ex_ready;
            e   = model_decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
            if (fir) exp_issued = exp_issued + 32'd1;
            if ((model_q.size() > 0) && !ex_ready) exp_stall = exp_stall + 32'd1;
            if (flush) begin
                model_q.delete();
                exp_illegal = 1'b0;
            end else begin
                if (fir) void'(model_q.pop_front());
                exp_illegal = acc && !e.legal;
                if (acc && e.legal) model_q.push_back(e);
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check_output("m_ex_valid", 32'(ex_valid), 32'(model_q.size() > 0));
            check_output("m_in_ready", 32'(in_ready), 32'(model_q.size() < 2));
            check_output("m_illegal", 32'(illegal), 32'(exp_illegal));
            if (model_q.size() > 0) begin
                check_output("m_ex_a", ex_a, model_q[0].a);
                check_output("m_ex_b", ex_b, model_q[0].b);
                check_output("m_ex_op", 32'(ex_op), 32'(model_q[0].op));
                check_output("m_ex_rd", 32'(ex_rd), 32'(model_q[0].rd));
                check_output("m_ex_we", 32'(ex_we), 32'(model_q[0].we));
            end
`ifdef ALU_ISSUE_PERF_EN
            check_output("m_perf_issued", perf_issued, exp_issued);
            check_output("m_perf_stall", perf_stall, exp_stall);
`endif
        end
    end

    // Drive one cycle of inputs starting at a falling edge; returns at the next falling edge.
    task automatic apply_stimulus(input logic v, input logic [31:0] ins, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] pc,
                                  input logic rdy, input logic fl);
        in_valid    = v;
        in_instr    = ins;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        in_pc       = pc;
        ex_ready    = rdy;
        flush       = fl;
        @(negedge clk);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    localparam logic [31:0] ADD_X3 = 32'h002081B3;
    localparam logic [31:0] SUB_X3 = 32'h402081B3;

    logic [31:0] vec [20];

    initial begin
        vec[0]  = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd4);
        vec[1]  = enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd5);
        vec[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd6);
        vec[3]  = enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd7);
        vec[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd8);
        vec[5]  = enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd9);
        vec[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd10);
        vec[7]  = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd11);
        vec[8]  = enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd12);
        vec[9]  = enc_r(7'h20, 5'd2, 5'd1, 3'd7, 5'd13);
        vec[10] = enc_i({7'h00, 5'd7}, 3'd1, 5'd14);
        vec[11] = enc_i({7'h20, 5'd7}, 3'd1, 5'd15);
        vec[12] = enc_i({7'h00, 5'd31}, 3'd5, 5'd16);
        vec[13] = enc_i(12'h800, 3'd4, 5'd17);
        vec[14] = enc_i(12'hFFE, 3'd3, 5'd18);
        vec[15] = {20'h12345, 5'd7, 7'b0110111};
        vec[16] = {20'hABCDE, 5'd19, 7'b0010111};
        vec[17] = {20'h00010, 5'd1, 7'b1101111};
        vec[18] = {20'h00001, 5'd0, 7'b0110111};
        vec[19] = enc_i({7'h10, 5'd3}, 3'd5, 5'd20);

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = 32'd0;
        in_pc       = 32'd0;
        in_rs1_data = 32'd0;
        in_rs2_data = 32'd0;
        flush       = 1'b0;
        ex_ready    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        check_output("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_ex_a", ex_a, 32'd0);
        check_output("rst_ex_b", ex_b, 32'd0);
        check_output("rst_ex_op", 32'(ex_op), 32'd0);
        check_output("rst_ex_rd", 32'(ex_rd), 32'd0);
        check_output("rst_ex_we", 32'(ex_we), 32'd0);
        check_output("rst_illegal", 32'(illegal), 32'd0);

        $display("[TB] basic decode");
        apply_stimulus(1, ADD_X3, 32'd5, 32'd7, 32'd0, 1, 0);
        check_output("add_valid", 32'(ex_valid), 32'd1);
        check_output("add_op", 32'(ex_op), 32'd0);
        check_output("add_a", ex_a, 32'd5);
        check_output("add_b", ex_b, 32'd7);
        check_output("add_rd", 32'(ex_rd), 32'd3);
        check_output("add_we", 32'(ex_we), 32'd1);
        apply_stimulus(1, 32'hFFF00093, 32'd0, 32'd0, 32'd0, 1, 0);
        check_output("addi_op", 32'(ex_op), 32'd0);
        check_output("addi_b", ex_b, 32'hFFFF_FFFF);
        check_output("addi_rd", 32'(ex_rd), 32'd1);
        apply_stimulus(1, 32'h40335293, 32'h8000_0000, 32'd0, 32'd0, 1, 0);
        check_output("srai_op", 32'(ex_op), 32'd7);
        check_output("srai_b", ex_b, 32'd3);
        check_output("srai_a", ex_a, 32'h8000_0000);
        apply_stimulus(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        check_output("drain_valid", 32'(ex_valid), 32'd0);

        $display("[TB] backpressure and skid");
        apply_stimulus(1, ADD_X3, 32'd1, 32'd2, 32'd0, 0, 0);
        check_output("stall1_op", 32'(ex_op), 32'd0);
        check_output("stall1_ready", 32'(in_ready), 32'd1);
        apply_stimulus(1, SUB_X3, 32'd10, 32'd3, 32'd0, 0, 0);
        check_output("stall2_ready", 32'(in_ready), 32'd0);
        check_output("stall2_op", 32'(ex_op), 32'd0);
        check_output("stall2_a", ex_a, 32'd1);
        apply_stimulus(1, 32'hFFF00093, 32'd9, 32'd9, 32'd0, 0, 0);
        check_output("stall3_a", ex_a, 32'd1);
        apply_stimulus(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        check_output("skid_op", 32'(ex_op), 32'd1);
        check_output("skid_a", ex_a, 32'd10);
        check_output("skid_ready", 32'(in_ready), 32'd1);
        apply_stimulus(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        check_output("skid_empty", 32'(ex_valid), 32'd0);

        $display("[TB] illegal and rd0");
        apply_stimulus(1, 32'h0000_0000, 32'd0, 32'd0, 32'd0, 1, 0);
        check_output("ill_pulse", 32'(illegal), 32'd1);
        check_output("ill_valid", 32'(ex_valid), 32'd0);
        apply_stimulus(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        check_output("ill_clear", 32'(illegal), 32'd0);
        apply_stimulus(1, 32'h00208033, 32'd4, 32'd4, 32'd0, 1, 0);
        check_output("rd0_we", 32'(ex_we), 32'd0);
        check_output("rd0_valid", 32'(ex_valid), 32'd1);
        apply_stimulus(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);

        $display("[TB] mixed vector table");
        for (int i = 0; i < 20; i++)
            apply_stimulus(1, vec[i], 32'h8000_0000 + 32'(i), 32'(i * 3), 32'h1000 + 32'(4 * i),
                           (i % 3) != 2, 0);
        repeat (3) apply_stimulus(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);

        $display("[TB] flush");
        apply_stimulus(1, ADD_X3, 32'd1, 32'd1, 32'd0, 0, 0);
        apply_stimulus(1, SUB_X3, 32'd2, 32'd2, 32'd0, 0, 0);
        apply_stimulus(1, ADD_X3, 32'd3, 32'd3, 32'd0, 0, 1);
        check_output("flush_valid", 32'(ex_valid), 32'd0);
        check_output("flush_ready", 32'(in_ready), 32'd1);
        check_output("flush_illegal", 32'(illegal), 32'd0);
        apply_stimulus(1, ADD_X3, 32'd4, 32'd4, 32'd0, 0, 0);
        apply_stimulus(1, 32'h0000_0000, 32'd0, 32'd0, 32'd0, 0, 1);
        check_output("flush_acc_illegal", 32'(illegal), 32'd0);
        check_output("flush_acc_valid", 32'(ex_valid), 32'd0);
        apply_stimulus(1, ADD_X3, 32'd5, 32'd5, 32'd0, 0, 0);
        apply_stimulus(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 1);
        check_output("flush_fire_valid", 32'(ex_valid), 32'd0);

        $display("[TB] async reset mid-stream");
        apply_stimulus(1, ADD_X3, 32'd9, 32'd9, 32'd0, 0, 0);
        apply_stimulus(1, SUB_X3, 32'd8, 32'd8, 32'd0, 0, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_output("arst_valid", 32'(ex_valid), 32'd0);
        check_output("arst_ready", 32'(in_ready), 32'd1);
        check_output("arst_a", ex_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] perf sequence");
        apply_stimulus(1, ADD_X3, 32'd1, 32'd1, 32'd0, 0, 0);
        repeat (4) apply_stimulus(0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0);
        apply_stimulus(1, ADD_X3, 32'd2, 32'd2, 32'd0, 1, 0);
        apply_stimulus(1, ADD_X3, 32'd3, 32'd3, 32'd0, 1, 0);
        apply_stimulus(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        check_output("perf_end_valid", 32'(ex_valid), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
        check_output("perf_issued", perf_issued, 32'd3);
        check_output("perf_stall", perf_stall, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the ALU interface. Decodes RV32I integer-ALU instructions (OP, OP-IMM, LUI, AUIPC) into the 4-bit ALU opcode and selects operands A and B.
- Holds the decoded bundle in a registered ID/EX stage with a 2-entry skid buffer and valid/ready handshakes on both sides.
- Sits between register-file read and the EX-stage alu. Its ex_* outputs drive the alu inputs A, B and Opcode directly.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- OPW, 4, ALU opcode width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_instr  in  32  raw instruction word.
- in_pc  in  32  instruction PC, used by AUIPC.
- in_rs1_data  in  32  rs1 register value.
- in_rs2_data  in  32  rs2 register value.
- flush  in  1  synchronous pipeline flush.
- ex_valid  out  1  EX bundle valid.
- ex_ready  in  1  EX stage accepts the bundle.
- ex_a  out  32  ALU operand A.
- ex_b  out  32  ALU operand B.
- ex_op  out  4  ALU opcode.
- ex_rd  out  5  destination register.
- ex_we  out  1  register write enable; 0 when rd==0.
- illegal  out  1  one-cycle pulse for an accepted non-ALU or malformed instruction.

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, ex_a=ex_b=0, ex_op=0, ex_rd=0, ex_we=0, illegal=0, skid empty, in_ready=1. Reset mid-transfer drops every held bundle.
- Accept = in_valid && in_ready. Fire = ex_valid && ex_ready. Latency from accept to ex_valid is 1 cycle.
- ALU opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- Decode for OP (0110011), where A=rs1 and B=rs2:
  - funct3 000: ADD if funct7 is 0x00, SUB if 0x20.
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU; each requires funct7=0x00.
  - 001 SLL requires funct7=0x00.
  - 101: SRL if funct7=0x00, SRA if 0x20.
- Decode for OP-IMM (0010011): A=rs1, B=sign-extended instr[31:20]. Same funct3 map with no SUB.
  - Shifts take B = zero-extended instr[24:20].
  - SLLI requires instr[31:25]=0x00. SRLI/SRAI require 0x00 or 0x20 respectively.
- Decode for LUI: A=0, B={instr[31:12],12'b0}, op ADD.
- Decode for AUIPC: A=in_pc, same B, op ADD.
- Any other opcode, or an illegal funct7: the instruction is accepted and consumed but never presented to EX. illegal=1 in the cycle after accept.
- ex_rd = instr[11:7]. ex_we = (rd != 0).
- Skid state machine, states {EMPTY, ONE(out), TWO(out+skid)}:
  - EMPTY --accept legal--> ONE.
  - ONE: accept && fire keeps ONE with new data. accept && !fire goes to TWO. Fire with no accept goes to EMPTY.
  - TWO: in_ready=0. Fire moves skid to out and goes to ONE.
- Ordering is strictly preserved. Outputs hold stable while ex_valid && !ex_ready.
- Flush has priority over all other events:
  - Next state is EMPTY and in_ready=1.
  - An instruction accepted in the flush cycle is discarded, with no illegal pulse.
  - Fire in the flush cycle still completes downstream.
- Operand data is captured at accept. No forwarding is done in this block.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- Defined: adds outputs perf_issued[31:0] (increments on each fire) and perf_stall[31:0] (increments each cycle ex_valid && !ex_ready). Both reset to 0, wrap at 2^32, and are not cleared by flush.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, ex_ready=1 → next cycle ex_valid=1, ex_op=0, ex_a=5, ex_b=7, ex_rd=3, ex_we=1.
- addi x1,x0,-1 (0xFFF00093), rs1=0 → ex_op=0, ex_b=0xFFFFFFFF, ex_rd=1; srai x5,x6,3 (0x40335293) → ex_op=7, ex_b=3.
- Hold ex_ready=0 and send add then sub (0x402081B3):
  - First bundle sits on ex_*; second goes to skid; in_ready=0 the next cycle.
  - Raise ex_ready → ex_op 0 then 1 on consecutive cycles; in_ready returns to 1.
- in_instr=0x00000000 accepted → illegal=1 for exactly one cycle, ex_valid stays 0; add with rd=0 (0x00208033) → ex_we=0.
- Fill both entries, then pulse flush with in_valid=1 → next cycle ex_valid=0, in_ready=1, no illegal pulse.
- Assert rst_n=0 mid-stream with both entries full → ex_valid and in_ready respond immediately (asynchronously), not on the next edge.
- With ALU_ISSUE_PERF_EN: 3 fires plus 4 stalled cycles → perf_issued=3, perf_stall=4.
